// File: rtl/mem_access_stage.sv
// Memory-access stage sitting behind the execute ALU.
// ALU results retire to writeback one cycle after acceptance. Loads and stores
// run a req/gnt(/rvalid) handshake with data memory while holding off execute.
// Byte ops get lane steering (SB) and lane select with zero-extension (LBU).
module mem_access_stage (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        is_byte_i,
  input  logic        wb_en_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] mem_addr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        xfer, mem_op;
  logic        op_load, op_byte, op_wb_en;
  logic [4:0]  op_rd;
  logic [31:0] op_addr, op_data;
  logic [3:0]       lane_be;
  logic [3:0][7:0]  lane_wd;
  logic [7:0]  rd_byte;
  logic [31:0] ld_data;

  // ready depends on state only, so there is no valid_i -> ready_o path
  assign ready_o = (state == IDLE);
  assign xfer    = valid_i & ready_o;
  // load wins when both class bits are set, so mem_op just ORs them
  assign mem_op  = is_load_i | is_store_i;

  // state register
  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: gnt only matters in REQ, rvalid only in RESP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && mem_op) state_nxt = REQ;
      REQ:     if (dmem_gnt_i)     state_nxt = op_load ? RESP : IDLE;
      RESP:    if (dmem_rvalid_i)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // capture the memory op so the request fields stay stable until grant
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      op_load  <= 1'b0;
      op_byte  <= 1'b0;
      op_wb_en <= 1'b0;
      op_rd    <= '0;
      op_addr  <= '0;
      op_data  <= '0;
    end else if (xfer && mem_op) begin
      op_load  <= is_load_i;
      op_byte  <= is_byte_i;
      op_wb_en <= wb_en_i;
      op_rd    <= rd_addr_i;
      op_addr  <= mem_addr_i;
      op_data  <= alu_result_i;
    end
  end

  // per-lane store steering: SB enables one lane and replicates the byte
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_be[i] = ~op_byte | (op_addr[1:0] == 2'(i));
    assign lane_wd[i] = op_byte ? op_data[7:0] : op_data[8*i +: 8];
  end

  // LBU picks the addressed byte and zero-extends; LW ignores addr[1:0]
  assign rd_byte = dmem_rdata_i[{op_addr[1:0], 3'b000} +: 8];
  assign ld_data = op_byte ? {24'h0, rd_byte} : dmem_rdata_i;

  // memory-side outputs, driven to zero whenever no request is up
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_be_o    = '0;
    if (state == REQ) begin
      dmem_req_o   = 1'b1;
      dmem_we_o    = ~op_load;
      dmem_addr_o  = {op_addr[31:2], 2'b00};
      dmem_wdata_o = op_load ? 32'h0 : lane_wd;
      dmem_be_o    = op_load ? 4'hF : lane_be;
    end
  end

  // writeback register: one-cycle retire pulse, wb_en only asserted with it
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wb_valid_o <= 1'b0;
      wb_en_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_en_o    <= 1'b0;
      if (xfer && !mem_op) begin
        wb_valid_o <= 1'b1;
        wb_en_o    <= wb_en_i;
        wb_addr_o  <= rd_addr_i;
        wb_data_o  <= alu_result_i;
      end else if (state == REQ && dmem_gnt_i && !op_load) begin
        wb_valid_o <= 1'b1;
        wb_addr_o  <= op_rd;
        wb_data_o  <= op_data;
      end else if (state == RESP && dmem_rvalid_i) begin
        wb_valid_o <= 1'b1;
        wb_en_o    <= op_wb_en;
        wb_addr_o  <= op_rd;
        wb_data_o  <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios followed by random traffic.
// Stimulus pushes expected requests/retirements into queues; a monitor pops
// and compares. A behavioural byte-addressed memory model predicts load data.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        valid_i = 1'b0, is_load_i = 1'b0, is_store_i = 1'b0, is_byte_i = 1'b0;
  logic        wb_en_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [31:0] alu_result_i = '0, mem_addr_i = '0;
  logic        ready_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  // memory responder: automatic mode or manual overrides from the main thread
  bit          auto_mem = 1'b0;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic        a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [31:0] a_rdata = '0;
  int          fix_gw = -1, fix_rw = -1;

  assign dmem_gnt_i    = auto_mem ? a_gnt    : man_gnt;
  assign dmem_rvalid_i = auto_mem ? a_rvalid : man_rvalid;
  assign dmem_rdata_i  = a_rdata;

  mem_access_stage dut (
    .clk(clk), .n_reset(n_reset), .valid_i(valid_i), .ready_o(ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .is_byte_i(is_byte_i),
    .wb_en_i(wb_en_i), .rd_addr_i(rd_addr_i), .alu_result_i(alu_result_i),
    .mem_addr_i(mem_addr_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;

  typedef struct { bit full; logic en; logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic we; logic [31:0] addr; bit st; logic [31:0] wdata; logic [3:0] be; } rq_t;
  wb_t exp_wb[$];
  rq_t exp_req[$];

  logic [31:0] wmem[int unsigned];   // responder's word memory
  logic [7:0]  bmem[int unsigned];   // reference model's byte memory

  // shared initial memory image (stimulus data, not a model of the DUT)
  function automatic logic [31:0] init_word(int unsigned a);
    if (a == 32'h100) return 32'hA1B2C3D4;
    if (a == 32'h200) return 32'h44332211;
    return (a * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] rd_word(int unsigned a);
    if (wmem.exists(a)) return wmem[a];
    return init_word(a);
  endfunction

  function automatic logic [7:0] model_rd(int unsigned a);
    logic [31:0] w;
    if (bmem.exists(a)) return bmem[a];
    w = init_word(a & ~32'd3);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    else passed++;
  endtask

  // issue one instruction; expectations are pushed at the accepting edge
  task automatic send(input bit ld, input bit st, input bit byt, input bit en,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] addr,
                      output int cyc);
    wb_t w;
    rq_t q;
    bit acc;
    int unsigned a, a4;
    is_load_i = ld; is_store_i = st; is_byte_i = byt; wb_en_i = en;
    rd_addr_i = rd; alu_result_i = alu; mem_addr_i = addr; valid_i = 1'b1;
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = ready_o;
      if (acc) begin
        a = addr; a4 = a & ~32'd3;
        w.rd = rd;
        if (ld) begin
          q.we = 1'b0; q.addr = a4; q.st = 1'b0; q.wdata = '0; q.be = '0;
          w.full = 1'b1; w.en = en;
          w.data = byt ? {24'h0, model_rd(a)}
                       : {model_rd(a4+3), model_rd(a4+2), model_rd(a4+1), model_rd(a4)};
          exp_req.push_back(q);
        end else if (st) begin
          q.we = 1'b1; q.addr = a4; q.st = 1'b1;
          if (byt) begin
            q.be = 4'b0001 << (a % 4);
            q.wdata = {4{alu[7:0]}};
            bmem[a] = alu[7:0];
          end else begin
            q.be = 4'hF;
            q.wdata = alu;
            for (int unsigned i = 0; i < 4; i++) bmem[a4+i] = alu[8*i +: 8];
          end
          w.full = 1'b0; w.en = 1'b0; w.data = '0;
          exp_req.push_back(q);
        end else begin
          w.full = 1'b1; w.en = en; w.data = alu;
        end
        exp_wb.push_back(w);
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid_i = 1'b0;
    if (!acc) begin
      total++;
      $display("FAIL accept: op not accepted within %0d cycles", cyc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wb.size() != 0 || exp_req.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(exp_wb.size() + exp_req.size()), 32'd0);
  endtask

  // memory responder: writes on granted stores, random or fixed grant/rvalid delays
  initial begin : responder
    bit wr;
    logic [31:0] wa, wd, w, ra;
    logic [3:0] wbe;
    int gw, rw;
    gw = -1; rw = -1; ra = '0;
    forever begin
      @(negedge clk);
      wr = n_reset && dmem_req_o && dmem_gnt_i && dmem_we_o;
      wa = dmem_addr_o; wd = dmem_wdata_o; wbe = dmem_be_o;
      @(posedge clk); #1;
      if (wr) begin
        w = rd_word(wa);
        for (int i = 0; i < 4; i++) if (wbe[i]) w[8*i +: 8] = wd[8*i +: 8];
        wmem[wa] = w;
      end
      a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = $urandom;
      if (!n_reset || !auto_mem) begin
        gw = -1; rw = -1;
      end else begin
        if (rw > 0) begin
          rw--;
          if (rw == 0) begin a_rvalid = 1'b1; a_rdata = rd_word(ra); rw = -1; end
        end
        if (dmem_req_o) begin
          if (gw < 0) gw = (fix_gw >= 0) ? fix_gw : int'($urandom_range(0, 3));
          if (gw == 0) begin
            a_gnt = 1'b1; gw = -1;
            if (!dmem_we_o) begin
              rw = (fix_rw > 0) ? fix_rw : int'($urandom_range(1, 4));
              ra = dmem_addr_o;
            end
          end else gw--;
        end
      end
    end
  end

  // monitor: compare each new request and each retirement with the queues
  logic        prev_req = 1'b0;
  logic [31:0] p_addr = '0, p_wd = '0;
  logic [4:0]  p_webe = '0;
  rq_t mq;
  wb_t mw;
  always @(negedge clk) begin
    if (!n_reset) prev_req = 1'b0;
    else begin
      if (dmem_req_o) begin
        if (!prev_req) begin
          if (exp_req.size() == 0) begin
            total++;
            $display("FAIL req_unexpected: addr 0x%08h with no op pending", dmem_addr_o);
          end else begin
            mq = exp_req.pop_front();
            chk("req_we", 32'(dmem_we_o), 32'(mq.we));
            chk("req_addr", dmem_addr_o, mq.addr);
            if (mq.st) begin
              chk("req_wdata", dmem_wdata_o, mq.wdata);
              chk("req_be", 32'(dmem_be_o), 32'(mq.be));
            end
          end
        end else begin
          chk("req_stable_addr", dmem_addr_o, p_addr);
          chk("req_stable_wdata", dmem_wdata_o, p_wd);
          chk("req_stable_webe", 32'({dmem_we_o, dmem_be_o}), 32'(p_webe));
        end
      end
      if (wb_valid_o) begin
        if (exp_wb.size() == 0) begin
          total++;
          $display("FAIL wb_unexpected: rd %0d data 0x%08h with no op pending", wb_addr_o, wb_data_o);
        end else begin
          mw = exp_wb.pop_front();
          chk("wb_en", 32'(wb_en_o), 32'(mw.en));
          if (mw.full) begin
            chk("wb_addr", 32'(wb_addr_o), 32'(mw.rd));
            chk("wb_data", wb_data_o, mw.data);
          end
        end
      end
      prev_req = dmem_req_o;
      p_addr = dmem_addr_o; p_wd = dmem_wdata_o; p_webe = {dmem_we_o, dmem_be_o};
    end
  end

  initial begin : main
    int cyc, n, k;
    bit ld, st, byt;
    // reset held two cycles with a stray rvalid
    man_rvalid = 1'b1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_req", 32'(dmem_req_o), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    end
    chk("rst_wb_en", 32'(wb_en_o), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_dmem_addr", dmem_addr_o, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata_o, 32'd0);
    chk("rst_dmem_be", 32'({dmem_we_o, dmem_be_o}), 32'd0);
    n_reset = 1'b1; man_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_release_wb_valid", 32'(wb_valid_o), 32'd0);
    @(posedge clk); #1;

    // back-to-back ALU ops
    auto_mem = 1'b1;
    send(0, 0, 0, 1, 5'd3, 32'h1, 32'h0, cyc);        chk("alu0_cycles", 32'(cyc), 32'd1);
    send(0, 0, 0, 1, 5'd4, 32'hDEADBEEF, 32'h0, cyc); chk("alu1_cycles", 32'(cyc), 32'd1);
    send(0, 0, 0, 1, 5'd5, 32'hFFFFFFFF, 32'h0, cyc); chk("alu2_cycles", 32'(cyc), 32'd1);
    @(negedge clk);
    chk("alu2_wb_valid", 32'(wb_valid_o), 32'd1);
    @(posedge clk); #1;

    // LW with 2 grant wait cycles and rvalid 3 cycles after grant
    fix_gw = 2; fix_rw = 3;
    send(1, 0, 0, 1, 5'd9, 32'h0, 32'h103, cyc);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (wb_valid_o) break;
      chk("lw_ready_low", 32'(ready_o), 32'd0);
    end
    chk("lw_latency", 32'(n), 32'd7);
    @(posedge clk); #1;

    // LBU on every lane, then SB/SW and a readback
    fix_gw = -1; fix_rw = -1;
    for (int b = 0; b < 4; b++) send(1, 0, 1, 1, 5'(10 + b), 32'h0, 32'h200 + 32'(b), cyc);
    send(0, 1, 1, 1, 5'd2, 32'h000000AB, 32'h206, cyc);
    send(0, 1, 0, 1, 5'd2, 32'h12345678, 32'h208, cyc);
    send(1, 0, 0, 1, 5'd6, 32'h0, 32'h204, cyc);
    drain();

    // reset while waiting for rvalid; late rvalid must not retire
    auto_mem = 1'b0;
    send(1, 0, 0, 1, 5'd8, 32'h0, 32'h10, cyc);
    man_gnt = 1'b1;
    @(posedge clk); #1;
    man_gnt = 1'b0;
    @(negedge clk);
    chk("resp_ready", 32'(ready_o), 32'd0);
    chk("resp_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk); #1;
    n_reset = 1'b0;
    exp_wb.delete();
    @(posedge clk); #1;
    n_reset = 1'b1; man_rvalid = 1'b1;
    @(posedge clk); #1;
    man_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rvalid_wb", 32'(wb_valid_o), 32'd0);
      chk("late_rvalid_ready", 32'(ready_o), 32'd1);
    end
    // stray rvalid while idle
    @(posedge clk); #1; man_rvalid = 1'b1;
    @(posedge clk); #1; man_rvalid = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_wb", 32'(wb_valid_o), 32'd0);
    @(posedge clk); #1;

    // grant coincides with a new valid_i: new op waits for IDLE
    send(0, 1, 0, 1, 5'd1, 32'hCAFEF00D, 32'h20, cyc);
    is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0; wb_en_i = 1'b1;
    rd_addr_i = 5'd7; alu_result_i = 32'h55; valid_i = 1'b1; man_gnt = 1'b1;
    @(negedge clk);
    chk("gnt_cycle_ready", 32'(ready_o), 32'd0);
    chk("gnt_cycle_req", 32'(dmem_req_o), 32'd1);
    @(posedge clk); #1;
    man_gnt = 1'b0;
    send(0, 0, 0, 1, 5'd7, 32'h55, 32'h0, cyc);
    chk("after_gnt_accept", 32'(cyc), 32'd1);
    drain();

    // random traffic against the byte-memory model
    auto_mem = 1'b1;
    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 5));
      ld = (k == 2 || k == 3);
      st = (k == 4 || k == 5) || (k == 2 && $urandom_range(0, 3) == 0);
      byt = (k == 3 || k == 5) || (k < 2 && $urandom_range(0, 1) == 1);
      send(ld, st, byt, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
           32'($urandom_range(0, 63)), cyc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
